uart_receiver: RTL

8N1 UART receiver; the receive-side counterpart to the team's uart_transmitter.
- Oversamples the asynchronous serial line with a baud counter.
- Validates the start bit at mid-bit, shifts in 8 data bits LSB first, and checks the stop bit.
- Presents each byte with a single-cycle valid strobe.
- Sits between the board RX pin and a consumer (FIFO or command parser). No backpressure.

---
 rtl/uart_receiver.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes i_RX, samples mid-bit, emits one-cycle valid/error strobes.
// Latency: strobe 3+HALF_BAUD-1+9*CLOCKS_PER_BAUD+1 cycles after the pin start edge; no backpressure.
module uart_receiver #(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int HALF_BAUD       = CLOCKS_PER_BAUD / 2
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_RX,
    output logic [7:0] o_DATA_OUT,
    output logic       o_DATA_VALID,
    output logic       o_FRAME_ERROR,
    output logic       o_RX_BUSY
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0] LP_BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] LP_HALF_LAST = CNT_W'(HALF_BAUD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic             w_fall;
    logic             w_baud_last;

    // Flops reset high so a line already idle does not look like a start edge.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall      = r_rx_prev & ~r_rx_s;
    assign w_baud_last = (r_baud_cnt == LP_BAUD_LAST);

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state       <= IDLE;
            r_baud_cnt    <= '0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            o_DATA_OUT    <= 8'h00;
            o_DATA_VALID  <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
            o_RX_BUSY     <= 1'b0;
        end else begin
            o_DATA_VALID  <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state    <= START;
                        r_baud_cnt <= '0;
                        o_RX_BUSY  <= 1'b1;
                    end
                end
                START: begin
                    if (r_baud_cnt == LP_HALF_LAST) begin
                        r_baud_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            r_state   <= IDLE;
                            o_RX_BUSY <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        // Back to IDLE at mid-stop so a following start edge is not missed.
                        r_baud_cnt <= '0;
                        r_state    <= IDLE;
                        o_RX_BUSY  <= 1'b0;
                        if (r_rx_s) begin
                            o_DATA_OUT   <= r_shift;
                            o_DATA_VALID <= 1'b1;
                        end else begin
                            o_FRAME_ERROR <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
